a_seq_driver: RTL and testbench

- Transmit-side counterpart of the two-bit A/K1/K2 sequence-detector FSM.
- On a `Go` command it drives the A line through one complete detector cycle: high, low, high, low, with programmable phase lengths.
- An optional checker watches the returned K2/K1 flags and reports pass/fail when the sequence completes.
- Sits beside the detector in the lab datapath, and doubles as its on-chip stimulus source.

---
 rtl/a_seq_pkg.sv | 29 ++
 rtl/a_seq_runlen.sv | 25 ++
 rtl/a_seq_driver.sv | 137 +++++++++++++
 tb/tb_a_seq_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/a_seq_pkg.sv
// Shared encodings for the A/K1/K2 sequence driver and its detector.
// Holds driver state codes, detector state codes and the zero-length rule.
package a_seq_pkg;

  localparam int PHASE_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI1  = 3'd1,
    LO1  = 3'd2,
    HI2  = 3'd3,
    LO2  = 3'd4,
    DONE = 3'd5
  } seq_state_e;

  // Detector state codes, shared so driver and detector benches agree.
  typedef enum logic [1:0] {
    DET_IDLE  = 2'd0,
    DET_START = 2'd1,
    DET_STOP  = 2'd2,
    DET_CLEAR = 2'd3
  } det_state_e;

  // A programmed phase length of 0 still produces a one-cycle phase.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/a_seq_runlen.sv
// Loadable down-counter timing each A phase; saturates at zero.
module a_seq_runlen #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (!Reset)                     cnt_q <= '0;
    else if (load)                  cnt_q <= load_val;
    else if (dec && cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/a_seq_driver.sv
// Drives A through high/low/high/low phases on Go; optional K1/K2 checker
// built when A_SEQ_DRIVER_CHECK_EN is defined (otherwise Pass is tied 0).
module a_seq_driver
  import a_seq_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEFAULT
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Go,
  input  logic [PHASE_W-1:0] HighLen,
  input  logic [PHASE_W-1:0] LowLen,
  input  logic               K2,
  input  logic               K1,
  output logic               A,
  output logic               Busy,
  output logic               Done,
  output logic               Pass,
  output logic [2:0]         state
);

  seq_state_e         state_q, state_d;
  logic [PHASE_W-1:0] hl_q, ll_q, hl_in, ll_in;
  logic [PHASE_W-1:0] cnt_val, cnt_unused;
  logic               cnt_load, cnt_dec, cnt_zero, accept;
  logic               a_q, busy_q, done_q;

  assign hl_in  = PHASE_W'(eff_len(32'(HighLen)));
  assign ll_in  = PHASE_W'(eff_len(32'(LowLen)));
  assign accept = (state_q == IDLE) && Go;

  a_seq_runlen #(.W(PHASE_W)) u_runlen (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .value    (cnt_unused),
    .zero     (cnt_zero)
  );

  // Each phase ends on the cycle its counter reads zero, reloading for the next.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: if (Go) begin
        state_d  = HI1;
        cnt_load = 1'b1;
        cnt_val  = hl_in - PHASE_W'(1);
      end
      HI1: if (cnt_zero) begin
        state_d  = LO1;
        cnt_load = 1'b1;
        cnt_val  = ll_q - PHASE_W'(1);
      end else cnt_dec = 1'b1;
      LO1: if (cnt_zero) begin
        state_d  = HI2;
        cnt_load = 1'b1;
        cnt_val  = hl_q - PHASE_W'(1);
      end else cnt_dec = 1'b1;
      HI2: if (cnt_zero) begin
        state_d  = LO2;
        cnt_load = 1'b1;
        cnt_val  = ll_q - PHASE_W'(1);
      end else cnt_dec = 1'b1;
      LO2: if (cnt_zero) state_d = DONE;
           else          cnt_dec = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      hl_q    <= '0;
      ll_q    <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hl_q <= hl_in;
        ll_q <= ll_in;
      end
      a_q    <= (state_d == HI1) || (state_d == HI2);
      busy_q <= (state_d == HI1) || (state_d == LO1) ||
                (state_d == HI2) || (state_d == LO2);
      done_q <= (state_d == DONE);
    end
  end

`ifdef A_SEQ_DRIVER_CHECK_EN
  logic seen_k1_q, seen_k2_q, seen_k1_d, seen_k2_d, win, pass_q;

  // Detector answers one edge behind A, so only the second half is watched.
  assign win = (state_q == HI2) || (state_q == LO2);

  always_comb begin
    seen_k1_d = seen_k1_q | (win & K1);
    seen_k2_d = seen_k2_q | (win & K2);
    if (accept) begin
      seen_k1_d = 1'b0;
      seen_k2_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      seen_k1_q <= 1'b0;
      seen_k2_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      seen_k1_q <= seen_k1_d;
      seen_k2_q <= seen_k2_d;
      pass_q    <= (state_d == DONE) && seen_k1_d && seen_k2_d;
    end
  end

  assign Pass = pass_q;
`else
  logic k_unused;
  assign k_unused = K1 ^ K2;
  assign Pass     = 1'b0;
`endif

  assign A     = a_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_a_seq_driver.sv
// Directed bench for a_seq_driver: vector table of full sequences plus
// hand-written reset, back-to-back and mid-run reset cases.
module tb_a_seq_driver;

`ifdef A_SEQ_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset, Go, K1, K2;
  logic [3:0] HighLen, LowLen;
  logic       A, Busy, Done, Pass;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  a_seq_driver #(.PHASE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Go(Go), .HighLen(HighLen), .LowLen(LowLen),
    .K2(K2), .K1(K1), .A(A), .Busy(Busy), .Done(Done), .Pass(Pass), .state(state)
  );

  typedef struct {
    int hl;
    int ll;
    int km;        // 0 none, 1 both in window, 2 only before window, 3 K2 only, 4 single pulses
    bit gomid;     // pulse Go during LO1
    int exp_busy;
    int exp_lat;
    bit exp_pass;
  } vec_t;

  vec_t vt[9];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && state != 3'd0; i++) step();
    chk("reach_idle", state, 3'd0);
  endtask

  task automatic run_seq(input vec_t v, input int idx);
    int h, l, busyc, donec, donecyc;
    logic [127:0] ea, aa;
    logic passv;
    bit win;
    string tag;
    h = (v.hl == 0) ? 1 : v.hl;
    l = (v.ll == 0) ? 1 : v.ll;
    ea = '0; aa = '0; busyc = 0; donec = 0; donecyc = -1; passv = 1'b0;
    for (int n = 1; n <= 2*h + 2*l; n++)
      ea[n] = (n <= h) || (n > h + l && n <= 2*h + l);
    tag = $sformatf("v%0d", idx);
    HighLen = 4'(v.hl); LowLen = 4'(v.ll); K1 = 0; K2 = 0; Go = 1;
    step();
    Go = 0;
    HighLen = 4'(v.hl + 5); LowLen = 4'(v.ll + 7);  // must not affect the run
    for (int n = 1; n <= v.exp_lat + 3; n++) begin
      aa[n] = A;
      busyc += int'(Busy);
      if (Done) begin
        donec++;
        donecyc = n;
        passv = Pass;
      end
      win = (n > h + l) && (n <= 2*h + 2*l);
      case (v.km)
        1: begin K1 = win; K2 = win; end
        2: begin K1 = (n <= h + l); K2 = (n <= h + l); end
        3: begin K1 = 0; K2 = win; end
        4: begin K1 = (n == h + l + 1); K2 = (n == 2*h + 2*l); end
        default: begin K1 = 0; K2 = 0; end
      endcase
      Go = v.gomid && (n > h) && (n <= h + l);
      step();
    end
    K1 = 0; K2 = 0; Go = 0;
    chk({tag, "_apattern"}, aa, ea);
    chk({tag, "_busylen"}, busyc, v.exp_busy);
    chk({tag, "_donecnt"}, donec, 1);
    chk({tag, "_donecyc"}, donecyc, v.exp_lat);
    chk({tag, "_pass"}, passv, v.exp_pass);
    chk({tag, "_endidle"}, state, 3'd0);
  endtask

  initial begin
    logic [127:0] ea, aa, ed, ad;
    int donec;

    vt[0] = '{hl:3,  ll:2,  km:1, gomid:0, exp_busy:10, exp_lat:11, exp_pass:CHK};
    vt[1] = '{hl:0,  ll:0,  km:1, gomid:0, exp_busy:4,  exp_lat:5,  exp_pass:CHK};
    vt[2] = '{hl:1,  ll:1,  km:0, gomid:0, exp_busy:4,  exp_lat:5,  exp_pass:1'b0};
    vt[3] = '{hl:2,  ll:2,  km:1, gomid:0, exp_busy:8,  exp_lat:9,  exp_pass:CHK};
    vt[4] = '{hl:2,  ll:2,  km:3, gomid:0, exp_busy:8,  exp_lat:9,  exp_pass:1'b0};
    vt[5] = '{hl:4,  ll:1,  km:2, gomid:0, exp_busy:10, exp_lat:11, exp_pass:1'b0};
    vt[6] = '{hl:15, ll:15, km:4, gomid:0, exp_busy:60, exp_lat:61, exp_pass:CHK};
    vt[7] = '{hl:2,  ll:3,  km:0, gomid:1, exp_busy:10, exp_lat:11, exp_pass:1'b0};
    vt[8] = '{hl:1,  ll:3,  km:4, gomid:1, exp_busy:8,  exp_lat:9,  exp_pass:CHK};

    // Reset held low with Go asserted: everything stays at zero.
    Reset = 0; Go = 1; K1 = 0; K2 = 0; HighLen = 0; LowLen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_outs%0d", i), {A, Busy, Done, Pass, state}, 7'd0);
    end
    Reset = 1;
    step();
    chk("post_reset_hi1", {state, A, Busy}, {3'd1, 1'b1, 1'b1});
    Go = 0;
    wait_idle();
    step();

    // Back-to-back Go with zero lengths: 6-cycle period, Go in DONE ignored.
    HighLen = 0; LowLen = 0; Go = 1;
    ea = '0; aa = '0; ed = '0; ad = '0;
    for (int n = 1; n <= 12; n++) begin
      step();
      aa[n] = A;
      ad[n] = Done;
      ea[n] = (n % 6 == 1) || (n % 6 == 3);
      ed[n] = (n == 5) || (n == 11);
    end
    Go = 0;
    chk("b2b_apattern", aa, ea);
    chk("b2b_done", ad, ed);
    wait_idle();
    step();

    // Reset during HI2 of a HighLen=4 run aborts with no Done.
    HighLen = 4; LowLen = 2; Go = 1;
    step();
    Go = 0;
    for (int n = 1; n < 7; n++) step();
    chk("midrst_in_hi2", state, 3'd3);
    Reset = 0;
    step();
    chk("midrst_outs", {A, Busy, Done, state}, 6'd0);
    Reset = 1;
    donec = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      donec += int'(Done);
    end
    chk("midrst_nodone", donec, 0);
    chk("midrst_idle", state, 3'd0);

    for (int i = 0; i < 9; i++) run_seq(vt[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
